// File: rtl/twofish_pkg.sv
// Shared Twofish definitions for the key schedule: FSM states, rho constant,
// rotate helper, GF(2^8) multiply and the nibble-table form of the q0/q1 permutations.
package twofish_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EVAL_A,
    EVAL_B,
    WR_EVEN,
    WR_ODD,
    DONE
  } ksched_state_e;

  localparam logic [31:0] RHO_C = 32'h01010101;

  // q-permutation nibble tables t0..t3, entry 0 in the most significant nibble
  localparam logic [63:0] Q0_T0 = 64'h817D6F320B59ECA4;
  localparam logic [63:0] Q0_T1 = 64'hECB81235F4A6709D;
  localparam logic [63:0] Q0_T2 = 64'hBA5E6D90C8F32471;
  localparam logic [63:0] Q0_T3 = 64'hD7F4126E9B3085CA;
  localparam logic [63:0] Q1_T0 = 64'h28BDF76E31940AC5;
  localparam logic [63:0] Q1_T1 = 64'h1E2B4C376DA5F908;
  localparam logic [63:0] Q1_T2 = 64'h4C75169A0ED82B3F;
  localparam logic [63:0] Q1_T3 = 64'hB951C3DE647F208A;

  function automatic logic [31:0] rol32(input logic [31:0] v, input logic [4:0] n);
    return (v << n) | (v >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [3:0] tnib(input logic [63:0] t, input logic [3:0] n);
    return t[{4'd15 - n, 2'b00} +: 4];
  endfunction

  function automatic logic [7:0] qperm(input logic [63:0] t0, input logic [63:0] t1,
                                       input logic [63:0] t2, input logic [63:0] t3,
                                       input logic [7:0] x);
    logic [3:0] a1, b1, a2, b2, a3, b3;
    a1 = x[7:4] ^ x[3:0];
    b1 = x[7:4] ^ {x[0], x[3:1]} ^ {x[4], 3'b000};
    a2 = tnib(t0, a1);
    b2 = tnib(t1, b1);
    a3 = a2 ^ b2;
    b3 = a2 ^ {b2[0], b2[3:1]} ^ {a2[0], 3'b000};
    return {tnib(t3, b3), tnib(t2, a3)};
  endfunction

  function automatic logic [7:0] q0(input logic [7:0] x);
    return qperm(Q0_T0, Q0_T1, Q0_T2, Q0_T3, x);
  endfunction

  function automatic logic [7:0] q1(input logic [7:0] x);
    return qperm(Q1_T0, Q1_T1, Q1_T2, Q1_T3, x);
  endfunction

  // Field polynomial x^8+x^6+x^5+x^3+1 (0x169)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] acc, p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h69 : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/h_func.sv
// Twofish h function for a 128-bit key (two key words): three q layers, then MDS.
module h_func
  import twofish_pkg::*;
(
  input  logic [31:0] X,
  input  logic [31:0] L0,
  input  logic [31:0] L1,
  output logic [31:0] y
);

  logic [7:0] s0, s1, s2, s3;

  // L1 is mixed in after the first q layer, L0 after the second
  assign s0 = q1(q0(q0(X[7:0])   ^ L1[7:0])   ^ L0[7:0]);
  assign s1 = q0(q0(q1(X[15:8])  ^ L1[15:8])  ^ L0[15:8]);
  assign s2 = q1(q1(q0(X[23:16]) ^ L1[23:16]) ^ L0[23:16]);
  assign s3 = q0(q1(q1(X[31:24]) ^ L1[31:24]) ^ L0[31:24]);

  mds u_mds (
    .y_in ({s3, s2, s1, s0}),
    .z    (y)
  );

endmodule

// File: rtl/mds.sv
// Twofish 4x4 MDS matrix multiply over GF(2^8); byte 0 of each word is y0/z0.
module mds
  import twofish_pkg::*;
(
  input  logic [31:0] y_in,
  output logic [31:0] z
);

  logic [7:0] y0, y1, y2, y3;

  assign y0 = y_in[7:0];
  assign y1 = y_in[15:8];
  assign y2 = y_in[23:16];
  assign y3 = y_in[31:24];

  assign z[7:0]   = y0 ^ gf_mul(y1, 8'hEF) ^ gf_mul(y2, 8'h5B) ^ gf_mul(y3, 8'h5B);
  assign z[15:8]  = gf_mul(y0, 8'h5B) ^ gf_mul(y1, 8'hEF) ^ gf_mul(y2, 8'hEF) ^ y3;
  assign z[23:16] = gf_mul(y0, 8'hEF) ^ gf_mul(y1, 8'h5B) ^ y2 ^ gf_mul(y3, 8'hEF);
  assign z[31:24] = gf_mul(y0, 8'hEF) ^ y1 ^ gf_mul(y2, 8'hEF) ^ gf_mul(y3, 8'h5B);

endmodule

// File: rtl/twofish_subkey_sched.sv
// Twofish 128-bit key subkey sequencer: four cycles per subkey pair through one
// shared h_func, writing K0..K(2*NUM_PAIRS-1) to the subkey RAM one word per cycle.
module twofish_subkey_sched
  import twofish_pkg::*;
#(
  parameter int unsigned NUM_PAIRS = 20,
  parameter logic [31:0] RHO       = RHO_C
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         sk_we,
  output logic [5:0]   sk_idx,
  output logic [31:0]  sk_data,
  output logic         done
);

  ksched_state_e state, state_nx;

  logic [4:0]  pair;
  logic [31:0] me0, me1, mo0, mo1;
  logic [31:0] a_reg, b_reg;
  logic [31:0] h_x, h_l0, h_l1, h_y;
  logic        sel_odd, last_pair;
  logic        busy_d, we_d, done_d;
  logic [5:0]  idx_d;
  logic [31:0] data_d;

  assign last_pair = (pair == 5'(NUM_PAIRS - 1));
  assign sel_odd   = (state == EVAL_B);

  // {pair, sel_odd} is 2i in EVAL_A and 2i+1 in EVAL_B
  assign h_x  = 32'({pair, sel_odd}) * RHO;
  assign h_l0 = sel_odd ? mo0 : me0;
  assign h_l1 = sel_odd ? mo1 : me1;

  h_func u_h (
    .X  (h_x),
    .L0 (h_l0),
    .L1 (h_l1),
    .y  (h_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy_d   = 1'b0;
    we_d     = 1'b0;
    done_d   = 1'b0;
    idx_d    = '0;
    data_d   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = EVAL_A;
          busy_d   = 1'b1;
        end
      end
      EVAL_A: begin
        state_nx = EVAL_B;
        busy_d   = 1'b1;
      end
      EVAL_B: begin
        state_nx = WR_EVEN;
        busy_d   = 1'b1;
      end
      WR_EVEN: begin
        state_nx = WR_ODD;
        busy_d   = 1'b1;
        we_d     = 1'b1;
        idx_d    = {pair, 1'b0};
        data_d   = a_reg + b_reg;
      end
      WR_ODD: begin
        state_nx = last_pair ? DONE : EVAL_A;
        busy_d   = 1'b1;
        we_d     = 1'b1;
        idx_d    = {pair, 1'b1};
        data_d   = rol32(a_reg + {b_reg[30:0], 1'b0}, 5'd9);
      end
      DONE: begin
        state_nx = IDLE;
        done_d   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      sk_we   <= 1'b0;
      sk_idx  <= '0;
      sk_data <= '0;
      done    <= 1'b0;
      pair    <= '0;
      me0     <= '0;
      me1     <= '0;
      mo0     <= '0;
      mo1     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
    end else begin
      busy    <= busy_d;
      sk_we   <= we_d;
      sk_idx  <= idx_d;
      sk_data <= data_d;
      done    <= done_d;
      case (state)
        IDLE: begin
          if (start) begin
            me0  <= key[31:0];
            me1  <= key[95:64];
            mo0  <= key[63:32];
            mo1  <= key[127:96];
            pair <= '0;
          end
        end
        EVAL_A:  a_reg <= h_y;
        EVAL_B:  b_reg <= rol32(h_y, 5'd8);
        WR_ODD:  if (!last_pair) pair <= pair + 5'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twofish_subkey_sched.sv
// Directed and random-key checks of the Twofish subkey sequencer against a
// bench-side Twofish key schedule model (bytewise q tables, long-division GF multiply).
module tb_twofish_subkey_sched;
  import twofish_pkg::*;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] key;
  logic         busy, sk_we, done;
  logic [5:0]   sk_idx;
  logic [31:0]  sk_data;

  int n_cmp = 0;
  int n_err = 0;

  twofish_subkey_sched #(.NUM_PAIRS(20), .RHO(32'h01010101)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .key     (key),
    .busy    (busy),
    .sk_we   (sk_we),
    .sk_idx  (sk_idx),
    .sk_data (sk_data),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int QT[2][4][16] = '{
    '{'{'h8,'h1,'h7,'hD,'h6,'hF,'h3,'h2,'h0,'hB,'h5,'h9,'hE,'hC,'hA,'h4},
      '{'hE,'hC,'hB,'h8,'h1,'h2,'h3,'h5,'hF,'h4,'hA,'h6,'h7,'h0,'h9,'hD},
      '{'hB,'hA,'h5,'hE,'h6,'hD,'h9,'h0,'hC,'h8,'hF,'h3,'h2,'h4,'h7,'h1},
      '{'hD,'h7,'hF,'h4,'h1,'h2,'h6,'hE,'h9,'hB,'h3,'h0,'h8,'h5,'hC,'hA}},
    '{'{'h2,'h8,'hB,'hD,'hF,'h7,'h6,'hE,'h3,'h1,'h9,'h4,'h0,'hA,'hC,'h5},
      '{'h1,'hE,'h2,'hB,'h4,'hC,'h3,'h7,'h6,'hD,'hA,'h5,'hF,'h9,'h0,'h8},
      '{'h4,'hC,'h7,'h5,'h1,'h6,'h9,'hA,'h0,'hE,'hD,'h8,'h2,'hB,'h3,'hF},
      '{'hB,'h9,'h5,'h1,'hC,'h3,'hD,'hE,'h6,'h4,'h7,'hF,'h2,'h0,'h8,'hA}}};

  localparam int MDSM[4][4] = '{'{'h01,'hEF,'h5B,'h5B}, '{'h5B,'hEF,'hEF,'h01},
                                '{'hEF,'h5B,'h01,'hEF}, '{'hEF,'h01,'hEF,'h5B}};

  logic [7:0]  q0t[256];
  logic [7:0]  q1t[256];
  logic [31:0] exp_k[40];

  function automatic logic [7:0] qcalc(input int s, input int x);
    int a, b, a2, b2;
    a  = x / 16;
    b  = x % 16;
    a2 = QT[s][0][a ^ b];
    b2 = QT[s][1][a ^ ((b >> 1) | ((b & 1) << 3)) ^ ((8 * a) % 16)];
    a  = QT[s][2][a2 ^ b2];
    b  = QT[s][3][a2 ^ ((b2 >> 1) | ((b2 & 1) << 3)) ^ ((8 * a2) % 16)];
    return 8'(16 * b + a);
  endfunction

  function automatic logic [7:0] gfm(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ ('h169 << (i - 8));
    return 8'(p);
  endfunction

  function automatic logic [31:0] rolm(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] hm(input logic [31:0] x, input logic [31:0] l0, input logic [31:0] l1);
    logic [7:0]  y[4];
    logic [31:0] z;
    y[0] = q1t[q0t[q0t[x[7:0]]   ^ l1[7:0]]   ^ l0[7:0]];
    y[1] = q0t[q0t[q1t[x[15:8]]  ^ l1[15:8]]  ^ l0[15:8]];
    y[2] = q1t[q1t[q0t[x[23:16]] ^ l1[23:16]] ^ l0[23:16]];
    y[3] = q0t[q1t[q1t[x[31:24]] ^ l1[31:24]] ^ l0[31:24]];
    z = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        z[8*r +: 8] = z[8*r +: 8] ^ gfm(MDSM[r][c], int'(y[c]));
    return z;
  endfunction

  task automatic build_model(input logic [127:0] k);
    logic [7:0]  e8, o8;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      e8 = 8'(2 * i);
      o8 = 8'(2 * i + 1);
      a  = hm({4{e8}}, k[31:0], k[95:64]);
      b  = rolm(hm({4{o8}}, k[63:32], k[127:96]), 8);
      exp_k[2*i]   = a + b;
      exp_k[2*i+1] = rolm(a + (b << 1), 9);
    end
  endtask

  // ---------------- capture ----------------
  int            n_wr, done_e, post_act;
  logic [5:0]    wr_idx[64];
  logic [31:0]   wr_data[64];
  int            wr_e[64];
  logic [127:0]  busy_h, we_h;
  logic [40:0]   rst_snap;
  ksched_state_e rst_state;

  // Edge 0 samples start; e counts clock edges after it, outputs sampled 1 time unit later.
  task automatic run(input logic [127:0] k, input int restart_e, input int rekey_e, input int rst_e);
    n_wr = 0; done_e = -1; post_act = 0; busy_h = '0; we_h = '0;
    key = k; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_h[0] = busy;
    for (int e = 1; e < 120; e++) begin
      @(posedge clk); #1;
      start = (e == restart_e);
      if (e == rekey_e) key = ~k;
      busy_h[e] = busy;
      we_h[e]   = sk_we;
      if (sk_we) begin
        if (n_wr < 64) begin
          wr_idx[n_wr] = sk_idx; wr_data[n_wr] = sk_data; wr_e[n_wr] = e;
        end
        n_wr++;
      end
      if (done) begin
        done_e = e;
        break;
      end
      if (e == rst_e) begin
        rst = 1'b1; #1;
        rst_snap  = {busy, sk_we, sk_idx, sk_data, done};
        rst_state = dut.state;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int j = 0; j < 12; j++) begin
          @(posedge clk); #1;
          if (sk_we || done || busy) post_act++;
        end
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_stream(input string s);
    chk({s, "_nwr"}, n_wr, 40);
    for (int n = 0; n < 40 && n < n_wr; n++) begin
      chk($sformatf("%s_idx%0d", s, n), wr_idx[n], n);
      chk($sformatf("%s_k%0d", s, n), wr_data[n], exp_k[n]);
    end
  endtask

  initial begin
    logic [127:0] bexp, wexp, k2;
    rst = 1'b0; start = 1'b0; key = '0;
    for (int x = 0; x < 256; x++) begin
      q0t[x] = qcalc(0, x);
      q1t[x] = qcalc(1, x);
    end
    #2 rst = 1'b1;
    #2;
    chk("reset_outs", {busy, sk_we, sk_idx, sk_data, done}, '0);
    chk("reset_state", dut.state, IDLE);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1/2: all-zero key, timing, busy and write-strobe shape
    build_model('0);
    run('0, 0, 0, 0);
    chk_stream("s1");
    chk("s1_k0_const", wr_data[0], 32'h52C54DDE);
    chk("s1_k1_const", wr_data[1], 32'h11F0626D);
    chk("s1_first_we_edge", wr_e[0], 3);
    chk("s1_last_we_edge", wr_e[39], 80);
    chk("s1_done_edge", done_e, 81);
    bexp = '0; wexp = '0;
    for (int e = 0; e <= 80; e++) begin
      bexp[e] = 1'b1;
      if (e >= 1 && (e % 4 == 3 || e % 4 == 0)) wexp[e] = 1'b1;
    end
    chk("s2_busy_shape", busy_h[81:0], bexp[81:0]);
    chk("s2_we_shape", we_h[81:0], wexp[81:0]);
    @(posedge clk); #1;
    chk("s1_done_one_cycle", {done, busy, sk_we}, '0);
    repeat (3) @(posedge clk); #1;

    // 3: start re-pulse and key change mid-run are ignored
    run('0, 30, 10, 0);
    chk_stream("s3");
    chk("s3_done_edge", done_e, 81);
    repeat (2) @(posedge clk); #1;

    // 4: reset just after the idx 14 write, then replay
    run('0, 0, 0, 31);
    chk("s4_nwr", n_wr, 15);
    chk("s4_last_idx", wr_idx[14], 14);
    chk("s4_rst_outs", rst_snap, '0);
    chk("s4_rst_state", rst_state, IDLE);
    chk("s4_post_reset_activity", post_act, 0);
    chk("s4_no_done", done_e, -1);
    run('0, 0, 0, 0);
    chk_stream("s4r");
    chk("s4r_done_edge", done_e, 81);

    // 5: back-to-back start while done is showing, new key
    k2 = 128'h0011223344556677_8899AABBCCDDEEFF;
    build_model(k2);
    run(k2, 0, 0, 0);
    chk_stream("s5");
    chk("s5_done_edge", done_e, 81);

    // 6: random keys
    for (int t = 0; t < 100; t++) begin
      k2 = {$urandom, $urandom, $urandom, $urandom};
      build_model(k2);
      run(k2, 0, 0, 0);
      chk_stream($sformatf("s6_%0d", t));
      chk($sformatf("s6_%0d_done_edge", t), done_e, 81);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
